// File: rtl/mpq_heap_param.sv
// Max-priority-queue engine: streaming batch load, then build/extract/
// increase/insert/write commands on a binary max-heap held in registers.
module mpq_heap_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data,
  input  logic              data_last,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd,
  input  logic [IDX_W-1:0]  index,
  input  logic [DATA_W-1:0] value,
  output logic              busy,
  output logic [IDX_W:0]    size,
  output logic              max_valid,
  output logic [DATA_W-1:0] max_data,
  output logic              err,
  output logic              RAM_valid,
  output logic [ADDR_W-1:0] RAM_A,
  output logic [DATA_W-1:0] RAM_D,
  output logic              done
);

  // Wide enough that 2*i+2 never wraps for any legal heap index.
  localparam int XW = IDX_W + 2;

  typedef enum logic [2:0] {
    LOAD, IDLE, HEAPIFY, SIFT_DN, SIFT_UP, WRITE, DONE
  } state_t;

  state_t              state, state_n;
  logic [DATA_W-1:0]   heap [DEPTH];
  logic [IDX_W:0]      cnt;
  logic [IDX_W:0]      cnt_m1;
  logic [IDX_W-1:0]    cur;
  logic [IDX_W:0]      kcnt;
  logic                building;
  logic [IDX_W:0]      wp;
  logic                err_n;

  logic [XW-1:0]       ix, lx, rx;
  logic                l_in, r_in;
  logic [DATA_W-1:0]   h_i, h_l, h_r, h_lg;
  logic [IDX_W-1:0]    lg, par;
  logic                dn_stop, up_stop;

  // Sift datapath shared by build, extract (down) and increase/insert (up).
  always_comb begin
    cnt_m1 = cnt - (IDX_W+1)'(1);
    ix     = XW'(cur);
    lx     = (ix << 1) + XW'(1);
    rx     = (ix << 1) + XW'(2);
    l_in   = lx < XW'(cnt);
    r_in   = rx < XW'(cnt);
    h_i    = heap[cur];
    h_l    = l_in ? heap[lx[IDX_W-1:0]] : '0;
    h_r    = r_in ? heap[rx[IDX_W-1:0]] : '0;
    lg     = cur;
    h_lg   = h_i;
    // Strict compares: parent wins ties, left child wins equal children.
    if (l_in && (h_l > h_lg)) begin
      lg   = lx[IDX_W-1:0];
      h_lg = h_l;
    end
    if (r_in && (h_r > h_lg)) begin
      lg   = rx[IDX_W-1:0];
      h_lg = h_r;
    end
    dn_stop = (lg == cur);
    par     = (cur - IDX_W'(1)) >> 1;
    up_stop = (cur == '0) || (heap[par] >= h_i);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_n;
  end

  // Next-state decode and command error detection.
  always_comb begin
    state_n = state;
    err_n   = 1'b0;
    case (state)
      LOAD: begin
        if (data_valid && (data_last || (cnt == (IDX_W+1)'(DEPTH - 1))))
          state_n = IDLE;
      end
      IDLE: begin
        if (cmd_valid) begin
          case (cmd)
            3'd0: state_n = HEAPIFY;
            3'd1: begin
              if (cnt == '0) err_n = 1'b1;
              else           state_n = SIFT_DN;
            end
            3'd2: begin
              if ({1'b0, index} >= cnt)    err_n = 1'b1;
              else if (value > heap[index]) state_n = SIFT_UP;
            end
            3'd3: begin
              if (cnt == (IDX_W+1)'(DEPTH)) err_n = 1'b1;
              else                          state_n = SIFT_UP;
            end
            3'd4:    state_n = (cnt == '0) ? DONE : WRITE;
            default: err_n = 1'b1;
          endcase
        end
      end
      HEAPIFY: state_n = (kcnt != '0) ? SIFT_DN : IDLE;
      SIFT_DN: begin
        if (dn_stop) state_n = building ? HEAPIFY : IDLE;
      end
      SIFT_UP: begin
        if (up_stop) state_n = IDLE;
      end
      WRITE: begin
        if (wp == cnt_m1) state_n = DONE;
      end
      DONE:    state_n = LOAD;
      default: state_n = LOAD;
    endcase
  end

  // Heap array, counters and registered pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned j = 0; j < DEPTH; j++) heap[j] <= '0;
      cnt       <= '0;
      cur       <= '0;
      kcnt      <= '0;
      building  <= 1'b0;
      wp        <= '0;
      max_valid <= 1'b0;
      max_data  <= '0;
      err       <= 1'b0;
    end else begin
      max_valid <= 1'b0;
      err       <= err_n;
      case (state)
        LOAD: begin
          if (data_valid) begin
            heap[cnt[IDX_W-1:0]] <= data;
            cnt                  <= cnt + (IDX_W+1)'(1);
          end
        end
        IDLE: begin
          if (cmd_valid) begin
            case (cmd)
              3'd0: begin
                // Build walks nodes size/2-1 .. 0; kcnt counts nodes left.
                kcnt     <= cnt >> 1;
                building <= 1'b1;
              end
              3'd1: begin
                if (state_n == SIFT_DN) begin
                  max_data                <= heap[0];
                  max_valid               <= 1'b1;
                  heap[0]                 <= heap[cnt_m1[IDX_W-1:0]];
                  // Later write wins, so a single-entry heap ends cleared.
                  heap[cnt_m1[IDX_W-1:0]] <= '0;
                  cnt                     <= cnt_m1;
                  cur                     <= '0;
                  building                <= 1'b0;
                end
              end
              3'd2: begin
                if (state_n == SIFT_UP) begin
                  heap[index] <= value;
                  cur         <= index;
                end
              end
              3'd3: begin
                if (state_n == SIFT_UP) begin
                  heap[cnt[IDX_W-1:0]] <= value;
                  cnt                  <= cnt + (IDX_W+1)'(1);
                  cur                  <= cnt[IDX_W-1:0];
                end
              end
              3'd4:    wp <= '0;
              default: ;
            endcase
          end
        end
        HEAPIFY: begin
          if (kcnt != '0) begin
            cur  <= kcnt[IDX_W-1:0] - IDX_W'(1);
            kcnt <= kcnt - (IDX_W+1)'(1);
          end
        end
        SIFT_DN: begin
          if (!dn_stop) begin
            heap[cur] <= h_lg;
            heap[lg]  <= h_i;
            cur       <= lg;
          end
        end
        SIFT_UP: begin
          if (!up_stop) begin
            heap[cur] <= heap[par];
            heap[par] <= h_i;
            cur       <= par;
          end
        end
        WRITE: wp <= wp + (IDX_W+1)'(1);
        DONE: begin
          for (int unsigned j = 0; j < DEPTH; j++) heap[j] <= '0;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Status and write-out port, zero outside WRITE.
  always_comb begin
    busy      = (state != IDLE);
    size      = cnt;
    done      = (state == DONE);
    RAM_valid = (state == WRITE);
    RAM_A     = RAM_valid ? ADDR_W'(wp) : '0;
    RAM_D     = RAM_valid ? heap[wp[IDX_W-1:0]] : '0;
  end

endmodule
